// File: rtl/fns_pkg.sv
// Shared types and elaboration helpers for the sequential FNS decoder.
// DPS_MSB_EN: when defined, fns_max_sum accounts for the doubled top-pair weight.
package fns_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } fns_state_e;

  function automatic int unsigned fns_chunks(input int unsigned code_w, input int unsigned bpc);
    return (code_w + bpc - 1) / bpc;
  endfunction

  // Largest weighted sum a code_w-bit codeword can produce (all ones).
  function automatic longint unsigned fns_max_sum(input int unsigned code_w);
    longint unsigned lo;
    longint unsigned hi;
    longint unsigned nx;
    longint unsigned sum;
    lo  = 1;
    hi  = 2;
    sum = 0;
    for (int unsigned i = 0; i < code_w; i++) begin
      sum = sum + lo;
`ifdef DPS_MSB_EN
      if (i == code_w - 2) sum = sum + lo;
`endif
      nx = lo + hi;
      lo = hi;
      hi = nx;
    end
    return sum;
  endfunction

endpackage

// File: rtl/fns_chunk_acc.sv
// Combinational FNS partial sum over one chunk of codeword bits; advances the weight pair per bit.
// DPS_MSB_EN: when defined, bit CODE_W-2 contributes twice its plain weight.
module fns_chunk_acc
  import fns_pkg::*;
#(
  parameter int unsigned CODE_W       = 37,
  parameter int unsigned BITS_PER_CYC = 4,
  parameter int unsigned DATA_W       = 27,
  parameter int unsigned IDX_W        = 6
) (
  input  logic [BITS_PER_CYC-1:0] i_bits,
  input  logic [DATA_W-1:0]       i_w_lo,
  input  logic [DATA_W-1:0]       i_w_hi,
  input  logic [IDX_W-1:0]        i_base_idx,
  output logic [DATA_W-1:0]       o_sum,
  output logic [DATA_W-1:0]       o_w_lo,
  output logic [DATA_W-1:0]       o_w_hi
);

  always_comb begin : p_acc
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_nx;
    logic [DATA_W-1:0] w_term;
    logic [IDX_W-1:0]  w_idx;
    o_sum  = '0;
    w_lo   = i_w_lo;
    w_hi   = i_w_hi;
    w_nx   = '0;
    w_term = '0;
    w_idx  = '0;
    for (int i = 0; i < int'(BITS_PER_CYC); i++) begin
      w_idx  = i_base_idx + IDX_W'(i);
      // Positions past the codeword in a partial last chunk contribute nothing.
      w_term = (i_bits[i] && (32'(w_idx) < CODE_W)) ? w_lo : '0;
`ifdef DPS_MSB_EN
      if (32'(w_idx) == CODE_W - 2) w_term = w_term << 1;
`endif
      o_sum = o_sum + w_term;
      w_nx  = w_lo + w_hi;
      w_lo  = w_hi;
      w_hi  = w_nx;
    end
    o_w_lo = w_lo;
    w_lo   = w_lo;
    o_w_hi = w_hi;
  end

endmodule

// File: rtl/fns_dec_seq.sv
// Multi-cycle Fibonacci-numeral-system decoder: one codeword per handshake, BITS_PER_CYC bits
// per clock LSB first, weights generated on the fly.
module fns_dec_seq
  import fns_pkg::*;
#(
  parameter int unsigned CODE_W       = 37,
  parameter int unsigned BITS_PER_CYC = 4,
  parameter int unsigned DATA_W       = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              busy
);

  localparam int unsigned CHUNKS = fns_chunks(CODE_W, BITS_PER_CYC);
  localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned IDX_W  = $clog2(CHUNKS * BITS_PER_CYC + 1);

  if (CODE_W < 3) begin : g_bad_code_w
    $error("CODE_W must be at least 3");
  end
  if (BITS_PER_CYC < 1 || BITS_PER_CYC > CODE_W) begin : g_bad_bpc
    $error("BITS_PER_CYC must be in 1..CODE_W");
  end
  if ((fns_max_sum(CODE_W) >> DATA_W) != 64'd0) begin : g_bad_data_w
    $error("DATA_W too narrow for the maximum weighted sum");
  end

  fns_state_e r_state, w_state_d;

  logic [CODE_W-1:0] r_shift;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_w_lo;
  logic [DATA_W-1:0] r_w_hi;
  logic [CNT_W-1:0]  r_chunk;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_w_lo;
  logic [DATA_W-1:0] w_w_hi;
  logic [DATA_W-1:0] w_acc_nx;
  logic [IDX_W-1:0]  w_base;
  logic              w_last;

  assign w_base   = IDX_W'(r_chunk) * IDX_W'(BITS_PER_CYC);
  assign w_last   = (r_chunk == CNT_W'(CHUNKS - 1));
  assign w_acc_nx = r_acc + w_sum;
  assign dataout  = r_dout;

  fns_chunk_acc #(
    .CODE_W      (CODE_W),
    .BITS_PER_CYC(BITS_PER_CYC),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) u_chunk_acc (
    .i_bits    (r_shift[BITS_PER_CYC-1:0]),
    .i_w_lo    (r_w_lo),
    .i_w_hi    (r_w_hi),
    .i_base_idx(w_base),
    .o_sum     (w_sum),
    .o_w_lo    (w_w_lo),
    .o_w_hi    (w_w_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_d = StAccum;
      end
      StAccum: begin
        busy = 1'b1;
        if (w_last) w_state_d = StDone;
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_dout  <= '0;
      r_w_lo  <= '0;
      r_w_hi  <= '0;
      r_chunk <= '0;
    end else if (r_state == StIdle && in_valid) begin
      r_shift <= codein;
      r_acc   <= '0;
      r_w_lo  <= DATA_W'(1);
      r_w_hi  <= DATA_W'(2);
      r_chunk <= '0;
    end else if (r_state == StAccum) begin
      r_shift <= r_shift >> BITS_PER_CYC;
      r_acc   <= w_acc_nx;
      r_w_lo  <= w_w_lo;
      r_w_hi  <= w_w_hi;
      r_chunk <= r_chunk + CNT_W'(1);
      // Result register updates only when the last chunk lands, keeping dataout stable.
      if (w_last) r_dout <= w_acc_nx;
    end
  end

endmodule

// File: tb/tb_fns_dec_seq.sv
// Scoreboard bench for fns_dec_seq: driver queues expected results, negedge monitor checks them.
module tb_fns_dec_seq;

  localparam int unsigned CODE_W = 37;
  localparam int unsigned BPC    = 4;
  localparam int unsigned DATA_W = 27;
  localparam int unsigned CHUNKS = 10;

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [CODE_W-1:0] codein = '0;
  logic              in_ready;
  logic              out_valid;
  logic              busy;
  logic [DATA_W-1:0] dataout;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                acc_q[$];
  vec_t              vecs[$];
  logic              prev_ov = 1'b0;

  fns_dec_seq #(
    .CODE_W      (CODE_W),
    .BITS_PER_CYC(BPC),
    .DATA_W      (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .codein   (codein),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dataout  (dataout),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: records accept edges, checks latency on out_valid rise and data on handshake.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL latency: out_valid rose with no accepted codeword");
        end else begin
          chk("latency", 64'(cyc - acc_q.pop_front()), 64'(CHUNKS));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL dataout: unexpected result %0d", dataout);
        end else begin
          chk("dataout", 64'(dataout), 64'(exp_q.pop_front()));
        end
      end
      prev_ov = out_valid;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [CODE_W-1:0] code, input logic [DATA_W-1:0] exp,
                      input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: in_ready=%0d required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    codein   = code;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || !in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    vecs.push_back('{37'h1, 27'd1});
    vecs.push_back('{37'hA, 27'd7});
    vecs.push_back('{37'h3, 27'd3});
    vecs.push_back('{37'h10, 27'd8});
    vecs.push_back('{37'hF0, 27'd76});
    vecs.push_back('{37'h15, 27'd12});
    vecs.push_back('{37'h4_0000_0000, 27'd14930352});
    vecs.push_back('{37'h10_0000_0000, 27'd39088169});
`ifdef DPS_MSB_EN
    vecs.push_back('{37'h1F_FFFF_FFFF, 27'd126491970});
    vecs.push_back('{37'h8_0000_0000, 27'd48315634});
`else
    vecs.push_back('{37'h1F_FFFF_FFFF, 27'd102334153});
    vecs.push_back('{37'h8_0000_0000, 27'd24157817});
`endif

    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_dataout", 64'(dataout), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) send(vecs[i].code, vecs[i].exp, 1'b1);
    drain();

    // Backpressure: result held in DONE, in_valid pulses must be ignored.
    out_ready = 1'b0;
    send(37'hA, 27'd7, 1'b1);
    for (int n = 0; n < 40 && !out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 1);
      codein   = 37'h1;
      chk("hold_dataout", 64'(dataout), 64'd7);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    // Release with in_valid high: not accepted on the handshake edge, accepted on the next.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    codein    = 37'h3;
    exp_q.push_back(27'd3);
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("reaccept_busy", 64'(busy), 64'd1);
    drain();

    // Reset during the 4th ACCUM cycle discards the codeword.
    send(37'h15, 27'd12, 1'b1);
    drain();
    send(37'hF0, 27'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_dataout", 64'(dataout), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(37'h1, 27'd1, 1'b1);
    drain();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
